prog_counter: RTL and testbench
===============================

Name: prog_counter

Overview:
- Parametrised successor to the team's 4-bit synchronous presettable binary counter.
- Generalised to WIDTH bits, with a runtime-programmable modulus (LIM), up/down direction, and a one-shot mode.
- Adds a registered wrap pulse and a sticky DONE flag.
- Used as a general timer/divider/event counter; cascadable through CET/TC like the 4-bit part.

Parameters:
WIDTH, 8, counter and data width in bits (legal range 2..32).

Ports:
CP  input  1  clock; all state changes on rising edge.
MR  input  1  master reset; synchronous, active-high.
CEP  input  1  count enable (parallel).
CET  input  1  count enable (trickle); also gates TC for cascading.
PE  input  1  parallel load enable, active-low.
D  input  WIDTH  parallel load data.
UD  input  1  direction: 1 = up, 0 = down.
LIM  input  WIDTH  terminal value; modulus = LIM+1.
ONESHOT  input  1  1 = stop at terminal instead of wrapping.
Q  output  WIDTH  counter value (registered).
TC  output  1  terminal count, combinational.
WRAP  output  1  one-cycle registered pulse on a wrap event.
DONE  output  1  sticky one-shot completion flag (registered).

Behaviour:
- Reset: MR=1 at a CP rising edge gives Q=0, WRAP=0, DONE=0. MR has priority over all other inputs. MR is sampled only on CP edges; there is no asynchronous effect.
- Priority per edge: MR > load (PE=0) > count > hold.
- Load (PE=0, MR=0):
  - Q <= D, DONE <= 0, WRAP <= 0.
  - Load ignores CEP, CET, UD, ONESHOT and DONE.
- Terminal condition `term`:
  - UD=1: term = (Q >= LIM). The >= covers values loaded above LIM.
  - UD=0: term = (Q == 0).
- TC = CET & term. Purely combinational and independent of CEP. It is still asserted while DONE=1.
- Count event: cen = CEP & CET & ~DONE, with MR=0 and PE=1.
- On cen with term=0:
  - Up: Q <= Q+1.
  - Down: Q <= Q-1.
  - WRAP <= 0.
- On cen with term=1 and ONESHOT=0:
  - Up: Q <= 0.
  - Down: Q <= LIM.
  - WRAP <= 1 for exactly one cycle.
- On cen with term=1 and ONESHOT=1:
  - Q holds, DONE <= 1, WRAP <= 1 for one cycle.
  - Further counting is inhibited until MR or load.
- No count event: Q holds, WRAP <= 0, DONE holds.
- Arithmetic: modulo 2^WIDTH internally, but the wrap rules above mean Q never passes through LIM+1..2^WIDTH-1 unless loaded there.
  - Up from Q > LIM: next count event goes to 0 (wrap), or stops (one-shot).
- LIM=0:
  - Up: term is always true; Q stays 0; WRAP pulses every enabled cycle (one-shot: DONE on the first event).
  - Down: Q wraps 0 -> 0.
- Direction change mid-count takes effect on the next edge; term is re-evaluated with the new UD.
- LIM change mid-count takes effect immediately in term/TC.
- Simultaneous MR and PE=0: reset wins. Simultaneous PE=0 and cen: load wins, no WRAP.
- ONESHOT deasserted while DONE=1: DONE stays set and counting stays inhibited until MR or load.
- All outputs are defined (no X) from the first CP edge with MR=1.

Test Plan:
- Reset/load: MR=1 one edge -> Q=0, WRAP=0, DONE=0. Then PE=0, D=8'h5A -> Q=8'h5A next edge. MR=1 with PE=0 on the same edge -> Q=0.
- Up modulo-10: LIM=9, UD=1, CEP=CET=1 from Q=0.
  - Q runs 0..9 then 0.
  - TC high only while Q=9.
  - WRAP high the cycle Q shows 0.
  - Drop CET -> TC=0 and Q holds.
- Down with wrap: LIM=5, UD=0, load D=2 -> Q = 2,1,0,5,4. TC=1 at Q=0. WRAP pulse coincides with Q=5.
- One-shot: ONESHOT=1, UD=1, LIM=3, start at 0.
  - Q = 1,2,3, then holds at 3.
  - DONE=1 and a single WRAP pulse.
  - 5 more enabled cycles -> Q=3, WRAP=0.
  - Load D=0 -> DONE=0 and counting resumes.
- Boundaries:
  - Load D=8'hF0 with LIM=8'h10, UD=1 -> next enabled edge Q=0 with WRAP.
  - LIM=0, UD=1 -> WRAP every enabled cycle, Q=0.
  - WIDTH=8, LIM=8'hFF -> Q goes FF->00 with WRAP.
- Cascade: two instances, TC of the low counter drives CET of the high counter, both LIM=8'hFF, both up.
  - After 300 edges -> {hi,lo} = 16'd300.
  - CEP=0 on the low counter freezes both.

Source files
------------

// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
// Module   : prog_counter
// Brief    : WIDTH-bit presettable up/down counter with programmable modulus,
//            one-shot mode, registered wrap pulse and sticky done flag.
// Revision : 1.0
// ============================================================================
module prog_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             CEP,
    input  logic             CET,
    input  logic             PE,
    input  logic [WIDTH-1:0] D,
    input  logic             UD,
    input  logic [WIDTH-1:0] LIM,
    input  logic             ONESHOT,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero = '0;

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_done;

    logic             w_term;
    logic             w_cen;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_reload;

    // Up uses >= so a value loaded above LIM still terminates on the next count.
    assign w_term   = UD ? (r_q >= LIM) : (r_q == c_zero);
    assign w_cen    = CEP & CET & ~r_done;
    assign w_step   = UD ? (r_q + c_one) : (r_q - c_one);
    assign w_reload = UD ? c_zero : LIM;

    always_ff @(posedge CP) begin
        if (MR) begin
            r_q    <= c_zero;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else if (!PE) begin
            r_q    <= D;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else if (w_cen) begin
            if (!w_term) begin
                r_q    <= w_step;
                r_wrap <= 1'b0;
            end else if (!ONESHOT) begin
                r_q    <= w_reload;
                r_wrap <= 1'b1;
            end else begin
                // One-shot: freeze at terminal until a reset or load re-arms.
                r_done <= 1'b1;
                r_wrap <= 1'b1;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign TC   = CET & w_term;
    assign WRAP = r_wrap;
    assign DONE = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prog_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_counter
// Brief    : Scoreboard bench for prog_counter: directed plan sequences plus
//            random stimulus, and a two-stage cascade run alongside.
// Revision : 1.0
// ============================================================================
module tb_prog_counter;

    typedef struct {
        bit        chk;
        bit [7:0]  q;
        bit        wrap;
        bit        done;
        bit        tc;
        bit [15:0] casc;
    } exp_t;

    logic       r_clk = 1'b0;
    logic       r_mr = 1'b0, r_cep = 1'b0, r_cet = 1'b0, r_pe = 1'b1;
    logic       r_ud = 1'b1, r_os = 1'b0;
    logic [7:0] r_d = '0, r_lim = '0;
    logic [7:0] w_q;
    logic       w_tc, w_wrap, w_done;

    logic       r_c_mr = 1'b0, r_c_cep = 1'b0;
    logic [7:0] w_lo_q, w_hi_q;
    logic       w_lo_tc, w_hi_tc, w_lo_wrap, w_hi_wrap, w_lo_done, w_hi_done;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t sb[$];

    // Reference state
    int   m_q = 0, m_wrap = 0, m_done = 0, m_casc = 0;
    bit   m_known = 0;

    always #5 r_clk = ~r_clk;

    prog_counter #(.WIDTH(8)) u_dut (
        .CP(r_clk), .MR(r_mr), .CEP(r_cep), .CET(r_cet), .PE(r_pe), .D(r_d),
        .UD(r_ud), .LIM(r_lim), .ONESHOT(r_os),
        .Q(w_q), .TC(w_tc), .WRAP(w_wrap), .DONE(w_done)
    );

    prog_counter #(.WIDTH(8)) u_lo (
        .CP(r_clk), .MR(r_c_mr), .CEP(r_c_cep), .CET(1'b1), .PE(1'b1), .D(8'h00),
        .UD(1'b1), .LIM(8'hFF), .ONESHOT(1'b0),
        .Q(w_lo_q), .TC(w_lo_tc), .WRAP(w_lo_wrap), .DONE(w_lo_done)
    );

    prog_counter #(.WIDTH(8)) u_hi (
        .CP(r_clk), .MR(r_c_mr), .CEP(r_c_cep), .CET(w_lo_tc), .PE(1'b1), .D(8'h00),
        .UD(1'b1), .LIM(8'hFF), .ONESHOT(1'b0),
        .Q(w_hi_q), .TC(w_hi_tc), .WRAP(w_hi_wrap), .DONE(w_hi_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: the DUT presents a fresh state every cycle; compare it mid-cycle.
    always @(negedge r_clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk) begin
                check("q",    {24'd0, w_q},           {24'd0, e.q});
                check("wrap", {31'd0, w_wrap},        {31'd0, e.wrap});
                check("done", {31'd0, w_done},        {31'd0, e.done});
                check("tc",   {31'd0, w_tc},          {31'd0, e.tc});
                check("casc", {16'd0, w_hi_q, w_lo_q}, {16'd0, e.casc});
            end
        end
    end

    // Apply one cycle of inputs, record the expected view, then advance the model.
    task automatic step(input bit mr, input bit pe, input bit [7:0] d, input bit cep,
                        input bit cet, input bit ud, input bit [7:0] lim, input bit os);
        exp_t e;
        bit   term;
        @(posedge r_clk);
        #1;
        r_mr = mr; r_pe = pe; r_d = d; r_cep = cep; r_cet = cet;
        r_ud = ud; r_lim = lim; r_os = os;
        r_c_mr  = (cyc == 0);
        if (cyc <= 300)      r_c_cep = 1'b1;
        else if (cyc <= 310) r_c_cep = 1'b0;
        else                 r_c_cep = ($urandom_range(0, 3) != 0);

        term   = ud ? (m_q >= int'(lim)) : (m_q == 0);
        e.chk  = m_known;
        e.q    = 8'(m_q);
        e.wrap = bit'(m_wrap);
        e.done = bit'(m_done);
        e.tc   = cet && term;
        e.casc = 16'(m_casc);
        sb.push_back(e);

        if (mr) begin
            m_q = 0; m_wrap = 0; m_done = 0;
        end else if (!pe) begin
            m_q = int'(d); m_wrap = 0; m_done = 0;
        end else if (cep && cet && (m_done == 0)) begin
            if (!term) begin
                m_q    = ud ? m_q + 1 : m_q - 1;
                m_wrap = 0;
            end else if (!os) begin
                m_q    = ud ? 0 : int'(lim);
                m_wrap = 1;
            end else begin
                m_wrap = 1;
                m_done = 1;
            end
        end else begin
            m_wrap = 0;
        end
        m_known = m_known | mr;

        if (r_c_mr)       m_casc = 0;
        else if (r_c_cep) m_casc = (m_casc + 1) % 65536;
        cyc++;
    endtask

    task automatic load(input bit [7:0] d, input bit [7:0] lim, input bit ud, input bit os);
        step(0, 0, d, 1, 1, ud, lim, os);
    endtask

    task automatic count(input int n, input bit cet, input bit [7:0] lim, input bit ud, input bit os);
        for (int i = 0; i < n; i++) step(0, 1, 8'h00, 1, cet, ud, lim, os);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, load, reset-beats-load
        step(1, 1, 8'h00, 0, 0, 1, 8'h09, 0);
        load(8'h5A, 8'h09, 1, 0);
        step(1, 0, 8'hA5, 1, 1, 1, 8'h09, 0);
        // Up modulo-10, then CET dropped
        count(12, 1, 8'h09, 1, 0);
        count(3, 0, 8'h09, 1, 0);
        // Down with wrap through LIM
        load(8'h02, 8'h05, 0, 0);
        count(6, 1, 8'h05, 0, 0);
        // One-shot: stop at terminal, stay stuck, re-arm by load
        load(8'h00, 8'h03, 1, 1);
        count(9, 1, 8'h03, 1, 1);
        count(2, 1, 8'h03, 1, 0);
        load(8'h00, 8'h03, 1, 1);
        count(3, 1, 8'h03, 1, 1);
        // Loaded above LIM, LIM=0 both directions, full-range wrap
        load(8'hF0, 8'h10, 1, 0);
        count(2, 1, 8'h10, 1, 0);
        load(8'h00, 8'h00, 1, 0);
        count(3, 1, 8'h00, 1, 0);
        count(2, 1, 8'h00, 0, 0);
        load(8'h00, 8'h00, 1, 1);
        count(2, 1, 8'h00, 1, 1);
        load(8'hFE, 8'hFF, 1, 0);
        count(3, 1, 8'hFF, 1, 0);

        // Let the cascade reach 300 and sit frozen before random traffic.
        while (cyc < 312) step(0, 1, 8'h00, $urandom_range(0, 1), 1, 1, 8'h0F, 0);

        for (int i = 0; i < 1500; i++) begin
            bit [7:0] lim;
            lim = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                 8'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 14)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 4) != 0, lim, $urandom_range(0, 3) == 0);
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge r_clk);
        @(posedge r_clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
